// File: rtl/lab3_pkg.sv
// Shared types and constants for the combination-lock key entry front end.
package lab3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } entry_state_t;

  localparam int MAX_DIGIT          = 9;
  localparam int DEFAULT_NUM_DIGITS = 6;

  // The whole switch bank is checked, so any upper switch raised is an error.
  function automatic logic is_bad_digit(input logic [9:0] v);
    return v > 10'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/key_entry_debounce_sync_2ff.sv
// Two-flop synchroniser with a configurable reset value per bit.
module sync_2ff #(
  parameter int                 DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] d_p0;
  logic [DATA_W-1:0] d_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_p0 <= RST_VAL;
      d_p1 <= RST_VAL;
    end else begin
      d_p0 <= d;
      d_p1 <= d_p0;
    end
  end

  assign q = d_p1;

endmodule

// File: rtl/key_entry_debounce.sv
// Debounces KEY0, captures SW[3:0] once per accepted press and tracks progress
// through a fixed-length digit entry sequence.
module key_entry_debounce
  import lab3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_DIGITS      = DEFAULT_NUM_DIGITS,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [9:0] sw,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       digit_err,
  output logic [2:0] entry_idx,
  output logic       entry_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             key_s;
  logic [9:0]       sw_s;
  entry_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_full;
  logic             accept;
  logic [2:0]       idx_nxt;

  sync_2ff #(.DATA_W(1), .RST_VAL(1'b1)) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_n),
    .q     (key_s)
  );

  sync_2ff #(.DATA_W(10), .RST_VAL(10'd0)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw),
    .q     (sw_s)
  );

  assign cnt_full = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter only advances below CNT_MAX, so it can never wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_full) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_full) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    accept  = (state == PRESS_WAIT) && !key_s && cnt_full;
    idx_nxt = entry_idx + 3'd1;
  end

  // digit_err is kept as a pure companion of the strobe; digit itself holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      digit_err   <= 1'b0;
      entry_idx   <= '0;
      entry_done  <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      digit_err   <= 1'b0;
      if (clear) begin
        entry_idx  <= '0;
        entry_done <= 1'b0;
      end else if (accept && !entry_done) begin
        digit       <= sw_s[3:0];
        digit_err   <= is_bad_digit(sw_s);
        digit_valid <= 1'b1;
        entry_idx   <= idx_nxt;
        entry_done  <= (idx_nxt == 3'(NUM_DIGITS));
      end
    end
  end

endmodule

// File: doc/key_entry_debounce.md
Name: key_entry_debounce

Overview:
Upstream front end for the combination-lock FSM in lab3_top. It synchronises and debounces the raw active-low KEY0 push-button and samples SW[3:0] on each accepted press. It delivers the value as a registered digit with a one-cycle digit_valid strobe. It also counts entries and flags completion of a six-digit sequence, so the lock advances exactly once per physical press instead of being clocked directly by the key.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or release (10 ms at 50 MHz); minimum 2.
NUM_DIGITS, 6, number of digits in one entry sequence.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width.

Ports:
clk  in  1  system clock (CLOCK_50).
rst_n  in  1  reset, asynchronous, active-low.
key_n  in  1  raw push-button, 0 = pressed, asynchronous.
sw  in  10  slide switches, quasi-static.
clear  in  1  synchronous restart of the entry sequence.
digit  out  4  value of sw[3:0] captured at the accepted press.
digit_valid  out  1  one-cycle strobe per accepted press.
digit_err  out  1  asserted with digit_valid when captured sw > 9.
entry_idx  out  3  number of digits delivered so far, 0..NUM_DIGITS.
entry_done  out  1  level; high once entry_idx == NUM_DIGITS.

Behaviour:
- Reset values: digit=0, digit_valid=0, digit_err=0, entry_idx=0, entry_done=0, FSM=IDLE, cnt=0, both key sync flops=1 (released), sw sync flops=0.
- key_n passes through a 2-flop synchroniser, giving key_s. sw passes through a matching 2-flop synchroniser, giving sw_s. No logic uses the raw inputs.
- IDLE: if key_s==0, go to PRESS_WAIT with cnt<=1.
- PRESS_WAIT:
  - key_s==1 (bounce): go to IDLE, cnt<=0.
  - key_s==0 and cnt==DEBOUNCE_CYCLES: go to HELD, cnt<=0, accept the press.
  - otherwise: cnt<=cnt+1.
- HELD: if key_s==1, go to RELEASE_WAIT with cnt<=1.
- RELEASE_WAIT:
  - key_s==0: go to HELD, cnt<=0.
  - key_s==1 and cnt==DEBOUNCE_CYCLES: go to IDLE.
  - otherwise: cnt<=cnt+1.
  - Release never produces a strobe.
- Latency: key_n first sampled low at edge k0 and held low, so the accept edge is k0+DEBOUNCE_CYCLES+2. Outputs are registered at that edge.
- At an accepted press, when entry_done==0 and clear==0:
  - digit<=sw_s[3:0], digit_err<=(sw_s>9), digit_valid<=1 for exactly one cycle.
  - entry_idx<=entry_idx+1; entry_done<=1 when the new value equals NUM_DIGITS.
- At an accepted press when entry_done==1: no strobe; digit, digit_err and entry_idx hold. The FSM still runs its normal press/release sequence.
- clear==1: entry_idx<=0, entry_done<=0, digit_valid<=0.
  - Clear wins over a coincident accepted press; that press is dropped, but the FSM still moves to HELD.
  - digit and digit_err hold their values.
- digit_err pulses only together with digit_valid; otherwise it is 0. An erroneous digit still counts as an entry.
- Holding the key indefinitely gives exactly one strobe. The next strobe requires a full debounced release followed by a new debounced press.
- rst_n asserted mid-operation, including during PRESS_WAIT or HELD, forces all reset values immediately. After rst_n deasserts, a key still held low is treated as a new press and is strobed after the full debounce latency.
- The counter saturates logic-wise at DEBOUNCE_CYCLES and never wraps.

Decomposition:
- lab3_pkg: the entry_state_t enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}, localparam MAX_DIGIT=9, and the default NUM_DIGITS.
- Sub-module sync_2ff (parameterised width), instantiated once for key_n (reset value 1) and once for sw (reset value 0).

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4.
1. Reset: rst_n=0 for 3 cycles with key_n=0 -> all outputs 0. After release of rst_n, a key held low strobes once, 6 edges after the first low sample.
2. Clean press: sw=7, key_n low for 20 cycles, then high -> exactly one digit_valid, digit=7, digit_err=0, entry_idx=1; nothing on release.
3. Bounce: key_n low for 3 cycles, high 1, low 2, high -> no strobe; FSM returns to IDLE and entry_idx stays 0.
4. Invalid digit: sw=10, clean press -> digit_valid=1, digit_err=1, digit=4'hA, entry_idx increments.
5. Full sequence: six clean presses of 7,2,2,2,9,7 -> six strobes, entry_idx=6, entry_done=1. A seventh press gives no strobe and no change.
6. Clear collision: assert clear on the exact accept cycle of a press -> digit_valid=0, entry_idx=0, entry_done=0. The next clean press gives entry_idx=1.
